// File: rtl/dm_mmio_bridge.sv
// Data-side memory-stage slave: word-organised RAM plus switch/LED/seven-segment/cycle-counter
// registers, with byte-lane store masking and sign/zero-extended combinational loads.
module dm_mmio_bridge #(
  parameter int          RAM_WORDS = 1024,
  parameter logic [15:0] SCAN_DIV  = 16'd50000,
  parameter logic [31:0] MMIO_BASE = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_w,
  input  logic [31:0] Addr_out,
  input  logic [31:0] Data_out,
  input  logic [2:0]  DMType,
  output logic [31:0] Data_in,
  input  logic [15:0] sw,
  output logic [15:0] led,
  output logic [7:0]  seg,
  output logic [7:0]  an,
  output logic        misalign
);

  localparam int          AW        = $clog2(RAM_WORDS);
  localparam logic [32:0] RAM_BYTES = 33'(RAM_WORDS) << 2;
  localparam logic [15:0] SCAN_LAST = SCAN_DIV - 16'd1;

  // Active-low {g..a} pattern for one hex digit.
  function automatic logic [6:0] hexToSeg(input logic [3:0] nib);
    case (nib)
      4'h0: hexToSeg = 7'h40;  4'h1: hexToSeg = 7'h79;
      4'h2: hexToSeg = 7'h24;  4'h3: hexToSeg = 7'h30;
      4'h4: hexToSeg = 7'h19;  4'h5: hexToSeg = 7'h12;
      4'h6: hexToSeg = 7'h02;  4'h7: hexToSeg = 7'h78;
      4'h8: hexToSeg = 7'h00;  4'h9: hexToSeg = 7'h10;
      4'hA: hexToSeg = 7'h08;  4'hB: hexToSeg = 7'h03;
      4'hC: hexToSeg = 7'h46;  4'hD: hexToSeg = 7'h21;
      4'hE: hexToSeg = 7'h06;  default: hexToSeg = 7'h0E;
    endcase
  endfunction

  logic [31:0]   ram [RAM_WORDS];
  logic [AW-1:0] wordIdx;
  logic          isByte, isHalf, isWord, aligned, ramHit, mmioHit, ramWe, mmioWe;
  logic [3:0]    byteEn;
  logic [31:0]   wrData, rawWord;
  logic [15:0]   halfSel;
  logic [7:0]    byteSel;

  logic [15:0] swMeta_q, swSync_q;
  logic [15:0] led_q, led_d;
  logic [31:0] segVal_q, segVal_d;
  logic [31:0] cyc_q, cyc_d;
  logic [15:0] scanDiv_q, scanDiv_d;
  logic [2:0]  digitIdx_q, digitIdx_d;
  logic [7:0]  an_q, an_d, seg_q, seg_d;
  logic        misalign_q, misalign_d;

  assign wordIdx = Addr_out[AW+1:2];

  // Access size, alignment and region decode shared by the load and store paths.
  always_comb begin
    isByte  = (DMType == 3'b011) || (DMType == 3'b100);
    isHalf  = (DMType == 3'b001) || (DMType == 3'b010);
    isWord  = !isByte && !isHalf;
    aligned = isWord ? (Addr_out[1:0] == 2'b00) : (isHalf ? !Addr_out[0] : 1'b1);
    ramHit  = {1'b0, Addr_out} < RAM_BYTES;
    mmioHit = Addr_out[31:4] == MMIO_BASE[31:4];
    ramWe   = mem_w && rst_n && ramHit && aligned;
    mmioWe  = mem_w && mmioHit && isWord && aligned;
    byteEn  = 4'b0000;
    if (isWord)      byteEn = 4'b1111;
    else if (isHalf) byteEn = Addr_out[1] ? 4'b1100 : 4'b0011;
    else             byteEn[Addr_out[1:0]] = 1'b1;
    wrData = isByte ? {4{Data_out[7:0]}} : (isHalf ? {2{Data_out[15:0]}} : Data_out);
  end

  always_ff @(posedge clk) begin
    if (ramWe) begin
      for (int b = 0; b < 4; b++) begin
        if (byteEn[b]) ram[wordIdx][8*b +: 8] <= wrData[8*b +: 8];
      end
    end
  end

  always_comb begin
    rawWord = '0;
    if (ramHit) begin
      rawWord = ram[wordIdx];
    end else if (mmioHit && isWord) begin
      case (Addr_out[3:2])
        2'd0:    rawWord = {16'b0, swSync_q};
        2'd1:    rawWord = {16'b0, led_q};
        2'd2:    rawWord = segVal_q;
        default: rawWord = cyc_q;
      endcase
    end
    halfSel = Addr_out[1] ? rawWord[31:16] : rawWord[15:0];
    byteSel = rawWord[{Addr_out[1:0], 3'b000} +: 8];
    Data_in = '0;
    if (aligned) begin
      case (DMType)
        3'b001:  Data_in = {{16{halfSel[15]}}, halfSel};
        3'b010:  Data_in = {16'b0, halfSel};
        3'b011:  Data_in = {{24{byteSel[7]}}, byteSel};
        3'b100:  Data_in = {24'b0, byteSel};
        default: Data_in = rawWord;
      endcase
    end
  end

  // A scan step latches the pre-edge SEG value, so a same-edge SEG write shows on the next step.
  always_comb begin
    led_d      = led_q;
    segVal_d   = segVal_q;
    cyc_d      = cyc_q + 32'd1;
    misalign_d = mem_w && !aligned;
    scanDiv_d  = scanDiv_q + 16'd1;
    digitIdx_d = digitIdx_q;
    an_d       = an_q;
    seg_d      = seg_q;
    if (mmioWe && (Addr_out[3:2] == 2'd1)) led_d    = Data_out[15:0];
    if (mmioWe && (Addr_out[3:2] == 2'd2)) segVal_d = Data_out;
    if (scanDiv_q == SCAN_LAST) begin
      scanDiv_d  = '0;
      digitIdx_d = digitIdx_q + 3'd1;
      an_d       = ~(8'b0000_0001 << digitIdx_d);
      seg_d      = {1'b1, hexToSeg(segVal_q[{digitIdx_d, 2'b00} +: 4])};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      swMeta_q   <= '0;
      swSync_q   <= '0;
      led_q      <= '0;
      segVal_q   <= '0;
      cyc_q      <= '0;
      scanDiv_q  <= '0;
      digitIdx_q <= '0;
      an_q       <= 8'hFE;
      seg_q      <= 8'hC0;
      misalign_q <= 1'b0;
    end else begin
      swMeta_q   <= sw;
      swSync_q   <= swMeta_q;
      led_q      <= led_d;
      segVal_q   <= segVal_d;
      cyc_q      <= cyc_d;
      scanDiv_q  <= scanDiv_d;
      digitIdx_q <= digitIdx_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
      misalign_q <= misalign_d;
    end
  end

  assign led      = led_q;
  assign seg      = seg_q;
  assign an       = an_q;
  assign misalign = misalign_q;

endmodule

// File: tb/tb_dm_mmio_bridge.sv
// Bench for dm_mmio_bridge: directed vector table, randomized traffic against a byte-array
// memory model, and hand-written scan/reset sequences.
module tb_dm_mmio_bridge;

  localparam int RAM_BYTES = 256;

  logic        clk = 1'b0, rst_n = 1'b0, mem_w = 1'b0;
  logic [31:0] Addr_out = '0, Data_out = '0, Data_in;
  logic [2:0]  DMType = '0;
  logic [15:0] sw = '0, led;
  logic [7:0]  seg, an;
  logic        misalign;

  int passCnt = 0, totalCnt = 0;

  logic [7:0]  mdl [RAM_BYTES];
  logic [15:0] mLed = '0, mSw = '0;
  logic [31:0] mSeg = '0;
  bit          expMis = 1'b0;
  logic [7:0]  segTab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] data;
    logic [2:0]  dm;
    logic [31:0] expRd;
  } vec_t;
  vec_t vecs[$];

  always #5 clk = ~clk;

  dm_mmio_bridge #(.RAM_WORDS(64), .SCAN_DIV(16'd2), .MMIO_BASE(32'hFFFF_0000)) dut (
    .clk(clk), .rst_n(rst_n), .mem_w(mem_w), .Addr_out(Addr_out), .Data_out(Data_out),
    .DMType(DMType), .Data_in(Data_in), .sw(sw), .led(led), .seg(seg), .an(an),
    .misalign(misalign)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    totalCnt++;
    if (act === exp) passCnt++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  function automatic int accessSize(input logic [2:0] dm);
    if (dm == 3'd1 || dm == 3'd2) return 2;
    if (dm == 3'd3 || dm == 3'd4) return 1;
    return 4;
  endfunction

  // Loads from a little-endian byte array, then extends per access type.
  function automatic logic [31:0] modelRead(input logic [31:0] addr, input logic [2:0] dm);
    int unsigned sz = accessSize(dm);
    logic [31:0] v = '0;
    if (addr % sz != 0) return '0;
    if (addr < RAM_BYTES) begin
      for (int k = 0; k < sz; k++) v = v | (32'(mdl[addr + k]) << (8 * k));
    end else if (addr >= 32'hFFFF_0000 && addr < 32'hFFFF_0010 && sz == 4) begin
      case (addr - 32'hFFFF_0000)
        32'h0:   v = {16'b0, mSw};
        32'h4:   v = {16'b0, mLed};
        32'h8:   v = mSeg;
        default: v = '0;
      endcase
    end
    if (dm == 3'd1 && v[15]) v = v | 32'hFFFF_0000;
    if (dm == 3'd3 && v[7])  v = v | 32'hFFFF_FF00;
    return v;
  endfunction

  function automatic void modelStore(input logic [31:0] addr, input logic [31:0] data,
                                     input logic [2:0] dm);
    int unsigned sz = accessSize(dm);
    expMis = (addr % sz != 0);
    if (expMis) return;
    if (addr < RAM_BYTES) begin
      for (int k = 0; k < sz; k++) mdl[addr + k] = data[8*k +: 8];
    end else if (sz == 4 && addr == 32'hFFFF_0004) begin
      mLed = data[15:0];
    end else if (sz == 4 && addr == 32'hFFFF_0008) begin
      mSeg = data;
    end
  endfunction

  task automatic applyStimulus(input bit we, input logic [31:0] addr, input logic [31:0] data,
                               input logic [2:0] dm, input bit chkRd, input logic [31:0] expRd);
    @(negedge clk);
    checkOutput("misalign", {31'b0, misalign}, {31'b0, expMis});
    checkOutput("led", {16'b0, led}, {16'b0, mLed});
    mem_w = we; Addr_out = addr; Data_out = data; DMType = dm;
    #1;
    if (chkRd) checkOutput("Data_in", Data_in, expRd);
    if (we) modelStore(addr, data, dm);
    else expMis = 1'b0;
  endtask

  task automatic idleCycle();
    @(negedge clk);
    checkOutput("misalign_idle", {31'b0, misalign}, {31'b0, expMis});
    mem_w = 1'b0;
    expMis = 1'b0;
  endtask

  task automatic resetDut();
    rst_n = 1'b0;
    mem_w = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    mLed = '0; mSeg = '0; expMis = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [31:0] a, d;
    logic [2:0]  dm;
    bit          we;
    int          r, n;

    vecs.push_back('{1, 32'h10, 32'h1234_5678, 3'd0, 32'h0});
    vecs.push_back('{0, 32'h10, 32'h0, 3'd0, 32'h1234_5678});
    vecs.push_back('{1, 32'h11, 32'h0000_0080, 3'd3, 32'h0});
    vecs.push_back('{0, 32'h10, 32'h0, 3'd0, 32'h1234_8078});
    vecs.push_back('{0, 32'h11, 32'h0, 3'd3, 32'hFFFF_FF80});
    vecs.push_back('{0, 32'h11, 32'h0, 3'd4, 32'h0000_0080});
    vecs.push_back('{1, 32'h12, 32'h0000_BEEF, 3'd1, 32'h0});
    vecs.push_back('{0, 32'h12, 32'h0, 3'd1, 32'hFFFF_BEEF});
    vecs.push_back('{0, 32'h12, 32'h0, 3'd2, 32'h0000_BEEF});
    vecs.push_back('{1, 32'h13, 32'h0000_1111, 3'd1, 32'h0});
    vecs.push_back('{0, 32'h10, 32'h0, 3'd0, 32'hBEEF_8078});
    vecs.push_back('{1, 32'hFFFF_0004, 32'h0000_A5A5, 3'd0, 32'h0});
    vecs.push_back('{0, 32'hFFFF_0004, 32'h0, 3'd0, 32'h0000_A5A5});
    vecs.push_back('{0, 32'hFFFF_0004, 32'h0, 3'd1, 32'h0});
    vecs.push_back('{0, 32'h13, 32'h0, 3'd0, 32'h0});
    vecs.push_back('{0, 32'h10, 32'h0, 3'd5, 32'hBEEF_8078});
    vecs.push_back('{1, 32'h14, 32'hCAFE_F00D, 3'd7, 32'h0});
    vecs.push_back('{0, 32'h14, 32'h0, 3'd0, 32'hCAFE_F00D});
    vecs.push_back('{0, 32'h15, 32'h0, 3'd7, 32'h0});
    vecs.push_back('{1, 32'h100, 32'h55AA_55AA, 3'd0, 32'h0});
    vecs.push_back('{0, 32'h100, 32'h0, 3'd0, 32'h0});
    vecs.push_back('{0, 32'hFFFF_0010, 32'h0, 3'd0, 32'h0});
    vecs.push_back('{0, 32'hFFFF_0000, 32'h0, 3'd0, 32'h0000_00F0});
    vecs.push_back('{0, 32'h16, 32'h0, 3'd4, 32'h0000_00FE});
    vecs.push_back('{0, 32'h17, 32'h0, 3'd3, 32'hFFFF_FFCA});
    vecs.push_back('{1, 32'hFFFF_0008, 32'h0000_1234, 3'd2, 32'h0});
    vecs.push_back('{0, 32'hFFFF_0008, 32'h0, 3'd0, 32'h0});

    #12;
    resetDut();
    checkOutput("reset_an", {24'b0, an}, 32'hFE);
    checkOutput("reset_seg", {24'b0, seg}, 32'hC0);
    checkOutput("reset_led", {16'b0, led}, 32'h0);
    checkOutput("reset_misalign", {31'b0, misalign}, 32'h0);
    applyStimulus(0, 32'hFFFF_000C, 32'h0, 3'd0, 1, 32'd1);

    sw = 16'h00F0; mSw = 16'h00F0;
    idleCycle(); idleCycle();

    foreach (vecs[i])
      applyStimulus(vecs[i].we, vecs[i].addr, vecs[i].data, vecs[i].dm, !vecs[i].we, vecs[i].expRd);

    // Randomized traffic: fill RAM to known contents first, since reset leaves it untouched.
    for (int w = 0; w < RAM_BYTES / 4; w++)
      applyStimulus(1, 32'(w * 4), $urandom, 3'd0, 0, 32'h0);
    sw = 16'($urandom); mSw = sw;
    idleCycle(); idleCycle();
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 9);
      if (r < 7)      a = 32'($urandom_range(0, RAM_BYTES - 1));
      else if (r < 8) a = 32'($urandom_range(RAM_BYTES, 2 * RAM_BYTES - 1));
      else            a = 32'hFFFF_0000 + 32'($urandom_range(0, 11));
      dm = 3'($urandom_range(0, 7));
      we = 1'($urandom_range(0, 1));
      d  = $urandom;
      applyStimulus(we, a, d, dm, 1, modelRead(a, dm));
    end
    idleCycle();

    // Scan: SEG write lands on the first step edge, so digit 1 still shows the old value.
    resetDut();
    applyStimulus(1, 32'hFFFF_0008, 32'h7654_3210, 3'd0, 0, 32'h0);
    for (n = 2; n <= 20; n++) begin
      idleCycle();
      checkOutput("scan_an", {24'b0, an}, {24'b0, ~(8'b1 << ((n / 2) % 8))});
      checkOutput("scan_seg", {24'b0, seg}, {24'b0, (n / 2 <= 1) ? 8'hC0 : segTab[(n / 2) % 8]});
    end

    applyStimulus(1, 32'hFFFF_0004, 32'h0000_A5A5, 3'd0, 0, 32'h0);
    applyStimulus(1, 32'h20, 32'h1122_3344, 3'd0, 0, 32'h0);
    @(negedge clk);
    checkOutput("led_before_reset", {16'b0, led}, 32'h0000_A5A5);
    mem_w = 1'b1; Addr_out = 32'h20; Data_out = 32'hDEAD_BEEF; DMType = 3'd0;
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_an", {24'b0, an}, 32'hFE);
    checkOutput("midreset_seg", {24'b0, seg}, 32'hC0);
    checkOutput("midreset_led", {16'b0, led}, 32'h0);
    repeat (2) @(negedge clk);
    mem_w = 1'b0;
    rst_n = 1'b1;
    mLed = '0; mSeg = '0; expMis = 1'b0;
    applyStimulus(0, 32'hFFFF_000C, 32'h0, 3'd0, 1, 32'd1);
    applyStimulus(0, 32'hFFFF_000C, 32'h0, 3'd0, 1, 32'd2);
    applyStimulus(0, 32'h20, 32'h0, 3'd0, 1, modelRead(32'h20, 3'd0));
    idleCycle();

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
